// File: rtl/number_match_game.sv
// Number-match game core: the player adds 4-bit values to a running total and
// wins by hitting TARGET exactly. The round is lost by overshooting TARGET or
// by using up MAX_TRIES additions. All state moves on the falling clock edge.
module number_match_game #(
   parameter logic [7:0] TARGET    = 8'd37,
   parameter logic [3:0] MAX_TRIES = 4'd8
) (
   input  logic       clk,
   input  logic       rts,
   input  logic       enable,
   input  logic       load,
   input  logic [3:0] num_in,
   output logic [7:0] sum,
   output logic [3:0] tries,
   output logic       playing,
   output logic       win,
   output logic       lose
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WIN  = 2'd2,
      LOSE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] sum_q, sum_d;
   logic [3:0] tries_q, tries_d;
   logic       load_q, load_d;
   logic       playing_q, playing_d;
   logic       win_q, win_d;
   logic       lose_q, lose_d;

   logic       load_event;
   logic [7:0] add_sum;
   logic [3:0] add_tries;

   // Next-state logic: round control, accumulation and win/lose evaluation.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      sum_d     = sum_q;
      tries_d   = tries_q;
      load_d    = load;
      // A press counts once: button high now, low at the previous edge.
      load_event = load & ~load_q;
      // Sum cannot wrap: at most 15 additions of 15 stay below 256.
      add_sum   = sum_q + {4'b0000, num_in};
      add_tries = tries_q + 4'd1;

      case (state_q)
         IDLE: begin
            // Button presses are ignored until the game is unlocked.
            if (enable) begin
               state_d = PLAY;
               sum_d   = 8'd0;
               tries_d = 4'd0;
            end
         end
         PLAY: begin
            if (!enable) begin
               state_d = IDLE;
               sum_d   = 8'd0;
               tries_d = 4'd0;
            end else if (load_event) begin
               sum_d   = add_sum;
               tries_d = add_tries;
               // Outcome is judged on the freshly updated totals.
               if (add_sum == TARGET) begin
                  state_d = WIN;
               end else if (add_sum > TARGET) begin
                  state_d = LOSE;
               end else if (add_tries == MAX_TRIES) begin
                  state_d = LOSE;
               end
            end
         end
         WIN, LOSE: begin
            // Losing the unlock has priority over starting a new round.
            if (!enable) begin
               state_d = IDLE;
               sum_d   = 8'd0;
               tries_d = 4'd0;
            end else if (load_event) begin
               state_d = PLAY;
               sum_d   = 8'd0;
               tries_d = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
            sum_d   = 8'd0;
            tries_d = 4'd0;
         end
      endcase

      // Status flags are derived from the next state so they register with it.
      playing_d = (state_d == PLAY);
      win_d     = (state_d == WIN);
      lose_d    = (state_d == LOSE);
   end

   // State register: falling-edge clocked, asynchronously cleared by rts.
   // NOTE: asynchronous reset clears every flop, including load_q, so a button held through reset is treated as freshly pressed but lands in IDLE where it is ignored.
   always_ff @(negedge clk or posedge rts) begin
      if (rts) begin
         state_q   <= IDLE;
         sum_q     <= 8'd0;
         tries_q   <= 4'd0;
         load_q    <= 1'b0;
         playing_q <= 1'b0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops sample the same pre-edge values.
         state_q   <= state_d;
         sum_q     <= sum_d;
         tries_q   <= tries_d;
         load_q    <= load_d;
         playing_q <= playing_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
      end
   end

   assign sum     = sum_q;
   assign tries   = tries_q;
   assign playing = playing_q;
   assign win     = win_q;
   assign lose    = lose_q;

endmodule
